// File: rtl/lock_detect.sv
// lock_detect: debounces the per-edge period_stable flag into a LOCKED indication.
// LOCKED rises after LOCK_CYCLES consecutive stable samples and falls after
// UNLOCK_TOL consecutive unstable samples; PWRDWN forces a quiet restart.
// Ports:
//   clk           sampling clock (same clock as the stability checker)
//   RST_N         asynchronous active-low reset
//   PWRDWN        synchronous power-down, active high
//   period_stable stability flag; anything other than a clean 1 counts as unstable
//   LOCKED        debounced lock indication (registered)
//   lock_lost     one-cycle pulse when lock is dropped by misses (registered)
//   stable_cnt    saturating count of consecutive stable samples (registered)
//   state         FSM state: 0 IDLE, 1 ACQ, 2 LOCK, 3 HOLD (registered)
module lock_detect #(
   parameter int unsigned LOCK_CYCLES = 8,
   parameter int unsigned UNLOCK_TOL  = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             RST_N,
   input  logic             PWRDWN,
   input  logic             period_stable,
   output logic             LOCKED,
   output logic             lock_lost,
   output logic [CNT_W-1:0] stable_cnt,
   output logic [1:0]       state
);

   // miss_cnt only ever holds 0..UNLOCK_TOL-1
   localparam int unsigned MISS_W = (UNLOCK_TOL > 1) ? $clog2(UNLOCK_TOL) : 1;

   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  LOCK_CNT = CNT_W'(LOCK_CYCLES);
   localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(UNLOCK_TOL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACQ  = 2'd1,
      LOCK = 2'd2,
      HOLD = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              locked_q, locked_d;
   logic              lost_q, lost_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [MISS_W-1:0] miss_q, miss_d;

   logic              s_c;
   logic [CNT_W-1:0]  cnt_inc_c;

   // Only a clean 1 is a stable sample; X/Z are treated as unstable.
   assign s_c       = (period_stable === 1'b1);
   assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // State and output registers
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= IDLE;
         locked_q <= 1'b0;
         lost_q   <= 1'b0;
         cnt_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         locked_q <= locked_d;
         lost_q   <= lost_d;
         cnt_q    <= cnt_d;
         miss_q   <= miss_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      locked_d = locked_q;
      lost_d   = 1'b0;
      miss_d   = miss_q;
      cnt_d    = s_c ? cnt_inc_c : '0;

      if (PWRDWN) begin
         state_d  = IDLE;
         locked_d = 1'b0;
         cnt_d    = '0;
         miss_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               locked_d = 1'b0;
               if (s_c) begin
                  if (LOCK_CYCLES == 1) begin
                     state_d  = LOCK;
                     locked_d = 1'b1;
                  end else begin
                     state_d = ACQ;
                  end
               end
            end
            ACQ: begin
               if (!s_c) begin
                  state_d = IDLE;
               end else if (cnt_d == LOCK_CNT) begin
                  state_d  = LOCK;
                  locked_d = 1'b1;
               end
            end
            LOCK: begin
               if (!s_c) begin
                  if (UNLOCK_TOL == 1) begin
                     state_d  = IDLE;
                     locked_d = 1'b0;
                     lost_d   = 1'b1;
                     miss_d   = '0;
                  end else begin
                     state_d = HOLD;
                     miss_d  = MISS_W'(1);
                  end
               end
            end
            HOLD: begin
               if (s_c) begin
                  state_d = LOCK;
                  miss_d  = '0;
               end else if (miss_q == MISS_MAX) begin
                  // this miss is the UNLOCK_TOL-th in a row
                  state_d  = IDLE;
                  locked_d = 1'b0;
                  lost_d   = 1'b1;
                  miss_d   = '0;
               end else begin
                  miss_d = miss_q + MISS_W'(1);
               end
            end
            default: begin
               state_d  = IDLE;
               locked_d = 1'b0;
               miss_d   = '0;
            end
         endcase
      end
   end

   assign LOCKED     = locked_q;
   assign lock_lost  = lost_q;
   assign stable_cnt = cnt_q;
   assign state      = state_q;

endmodule

// File: tb/tb_lock_detect.sv
// Directed bench for lock_detect: default parameters, a narrow saturating
// counter variant, and the single-sample lock/unlock variant.
module tb_lock_detect;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, pwrdwn, stab;

   // default: LOCK_CYCLES=8, UNLOCK_TOL=2, CNT_W=16
   logic        lk_a, ll_a;
   logic [15:0] cnt_a;
   logic [1:0]  st_a;
   // CNT_W=3, LOCK_CYCLES=7
   logic        lk_b, ll_b;
   logic [2:0]  cnt_b;
   logic [1:0]  st_b;
   // LOCK_CYCLES=1, UNLOCK_TOL=1
   logic        lk_c, ll_c;
   logic [15:0] cnt_c;
   logic [1:0]  st_c;

   int n_tests = 0;
   int n_fail  = 0;

   lock_detect u_a (
      .clk(clk), .RST_N(rst_n), .PWRDWN(pwrdwn), .period_stable(stab),
      .LOCKED(lk_a), .lock_lost(ll_a), .stable_cnt(cnt_a), .state(st_a));

   lock_detect #(.LOCK_CYCLES(7), .UNLOCK_TOL(2), .CNT_W(3)) u_b (
      .clk(clk), .RST_N(rst_n), .PWRDWN(pwrdwn), .period_stable(stab),
      .LOCKED(lk_b), .lock_lost(ll_b), .stable_cnt(cnt_b), .state(st_b));

   lock_detect #(.LOCK_CYCLES(1), .UNLOCK_TOL(1), .CNT_W(16)) u_c (
      .clk(clk), .RST_N(rst_n), .PWRDWN(pwrdwn), .period_stable(stab),
      .LOCKED(lk_c), .lock_lost(ll_c), .stable_cnt(cnt_c), .state(st_c));

   // Apply n samples of value s; returns 1 time unit after the last edge.
   task automatic tick(input logic s, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         stab = s;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      pwrdwn = 1'b0;
      stab   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      pwrdwn = 1'b0;
      stab   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({st_a, lk_a, ll_a, cnt_a} !== {2'd0, 1'b0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_hold: state=%0d LOCKED=%b lost=%b cnt=%0d, want 0/0/0/0",
                  st_a, lk_a, ll_a, cnt_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) begin
            n_tests++;
            if (st_a !== 2'd1 || cnt_a !== 16'd1) begin
               n_fail++;
               $display("FAIL reset_acq: state=%0d cnt=%0d, want 1/1", st_a, cnt_a);
            end
         end
         if (e < 8) begin
            n_tests++;
            if (lk_a !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_early_lock edge %0d: LOCKED=%b, want 0", e, lk_a);
            end
         end
      end
      n_tests++;
      if ({st_a, lk_a, cnt_a} !== {2'd2, 1'b1, 16'd8}) begin
         n_fail++;
         $display("FAIL reset_lock8: state=%0d LOCKED=%b cnt=%0d, want 2/1/8",
                  st_a, lk_a, cnt_a);
      end
   endtask

   task automatic test_async_reset();
      // u_a is locked here; assert reset between edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({st_a, lk_a, cnt_a} !== {2'd0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL async_reset: state=%0d LOCKED=%b cnt=%0d, want 0/0/0",
                  st_a, lk_a, cnt_a);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_interrupted_acq();
      do_reset();
      tick(1'b1, 5);
      n_tests++;
      if ({st_a, lk_a, cnt_a} !== {2'd1, 1'b0, 16'd5}) begin
         n_fail++;
         $display("FAIL acq5: state=%0d LOCKED=%b cnt=%0d, want 1/0/5", st_a, lk_a, cnt_a);
      end
      tick(1'b0, 1);
      n_tests++;
      if ({st_a, lk_a, cnt_a} !== {2'd0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL acq_break: state=%0d LOCKED=%b cnt=%0d, want 0/0/0", st_a, lk_a, cnt_a);
      end
      tick(1'b1, 7);
      n_tests++;
      if ({lk_a, cnt_a} !== {1'b0, 16'd7}) begin
         n_fail++;
         $display("FAIL reacq7: LOCKED=%b cnt=%0d, want 0/7", lk_a, cnt_a);
      end
      tick(1'b1, 1);
      n_tests++;
      if ({st_a, lk_a, cnt_a} !== {2'd2, 1'b1, 16'd8}) begin
         n_fail++;
         $display("FAIL reacq8: state=%0d LOCKED=%b cnt=%0d, want 2/1/8", st_a, lk_a, cnt_a);
      end
   endtask

   task automatic test_hold();
      // continues from the locked state of the previous task
      tick(1'b0, 1);
      n_tests++;
      if ({st_a, lk_a, ll_a, cnt_a} !== {2'd3, 1'b1, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL hold: state=%0d LOCKED=%b lost=%b cnt=%0d, want 3/1/0/0",
                  st_a, lk_a, ll_a, cnt_a);
      end
      tick(1'b1, 1);
      n_tests++;
      if ({st_a, lk_a, ll_a, cnt_a} !== {2'd2, 1'b1, 1'b0, 16'd1}) begin
         n_fail++;
         $display("FAIL hold_recover: state=%0d LOCKED=%b lost=%b cnt=%0d, want 2/1/0/1",
                  st_a, lk_a, ll_a, cnt_a);
      end
   endtask

   task automatic test_unlock();
      // a recovered miss must not count toward the next drop
      tick(1'b0, 1);
      n_tests++;
      if ({st_a, lk_a, ll_a} !== {2'd3, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL unlock_miss1: state=%0d LOCKED=%b lost=%b, want 3/1/0", st_a, lk_a, ll_a);
      end
      tick(1'b0, 1);
      n_tests++;
      if ({st_a, lk_a, ll_a} !== {2'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL unlock_miss2: state=%0d LOCKED=%b lost=%b, want 0/0/1", st_a, lk_a, ll_a);
      end
      tick(1'b0, 1);
      n_tests++;
      if ({st_a, lk_a, ll_a} !== {2'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL unlock_pulse_len: state=%0d LOCKED=%b lost=%b, want 0/0/0",
                  st_a, lk_a, ll_a);
      end
      // no fast relock
      tick(1'b1, 7);
      n_tests++;
      if ({st_a, lk_a} !== {2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL no_fast_relock: state=%0d LOCKED=%b, want 1/0", st_a, lk_a);
      end
      tick(1'b1, 1);
      n_tests++;
      if ({st_a, lk_a} !== {2'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL relock: state=%0d LOCKED=%b, want 2/1", st_a, lk_a);
      end
   endtask

   task automatic test_pwrdwn();
      // u_a is locked here
      @(negedge clk);
      pwrdwn = 1'b1;
      stab   = 1'bx;
      @(posedge clk);
      #1;
      n_tests++;
      if ({st_a, lk_a, ll_a, cnt_a} !== {2'd0, 1'b0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL pwrdwn: state=%0d LOCKED=%b lost=%b cnt=%0d, want 0/0/0/0",
                  st_a, lk_a, ll_a, cnt_a);
      end
      @(negedge clk);
      pwrdwn = 1'b0;
      tick(1'bx, 1);
      tick(1'bz, 1);
      n_tests++;
      if ({st_a, lk_a, ll_a, cnt_a} !== {2'd0, 1'b0, 1'b0, 16'd0}) begin
         n_fail++;
         $display("FAIL xz_unstable: state=%0d LOCKED=%b lost=%b cnt=%0d, want 0/0/0/0",
                  st_a, lk_a, ll_a, cnt_a);
      end
      tick(1'b1, 1);
      n_tests++;
      if ({st_a, cnt_a} !== {2'd1, 16'd1}) begin
         n_fail++;
         $display("FAIL after_xz: state=%0d cnt=%0d, want 1/1", st_a, cnt_a);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      tick(1'b1, 6);
      n_tests++;
      if ({lk_b, cnt_b} !== {1'b0, 3'd6}) begin
         n_fail++;
         $display("FAIL sat_pre: LOCKED=%b cnt=%0d, want 0/6", lk_b, cnt_b);
      end
      tick(1'b1, 1);
      n_tests++;
      if ({st_b, lk_b, cnt_b} !== {2'd2, 1'b1, 3'd7}) begin
         n_fail++;
         $display("FAIL sat_lock: state=%0d LOCKED=%b cnt=%0d, want 2/1/7", st_b, lk_b, cnt_b);
      end
      tick(1'b1, 1);
      n_tests++;
      if ({lk_b, cnt_b} !== {1'b1, 3'd7}) begin
         n_fail++;
         $display("FAIL sat_edge8: LOCKED=%b cnt=%0d, want 1/7", lk_b, cnt_b);
      end
      tick(1'b1, 12);
      n_tests++;
      if ({st_b, lk_b, cnt_b} !== {2'd2, 1'b1, 3'd7}) begin
         n_fail++;
         $display("FAIL sat_edge20: state=%0d LOCKED=%b cnt=%0d, want 2/1/7", st_b, lk_b, cnt_b);
      end
   endtask

   task automatic test_fast();
      do_reset();
      tick(1'b1, 1);
      n_tests++;
      if ({st_c, lk_c, ll_c, cnt_c} !== {2'd2, 1'b1, 1'b0, 16'd1}) begin
         n_fail++;
         $display("FAIL fast_lock: state=%0d LOCKED=%b lost=%b cnt=%0d, want 2/1/0/1",
                  st_c, lk_c, ll_c, cnt_c);
      end
      tick(1'b0, 1);
      n_tests++;
      if ({st_c, lk_c, ll_c, cnt_c} !== {2'd0, 1'b0, 1'b1, 16'd0}) begin
         n_fail++;
         $display("FAIL fast_unlock: state=%0d LOCKED=%b lost=%b cnt=%0d, want 0/0/1/0",
                  st_c, lk_c, ll_c, cnt_c);
      end
      tick(1'b0, 1);
      n_tests++;
      if ({st_c, lk_c, ll_c} !== {2'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL fast_pulse_len: state=%0d LOCKED=%b lost=%b, want 0/0/0",
                  st_c, lk_c, ll_c);
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_interrupted_acq();
      test_hold();
      test_unlock();
      test_pwrdwn();
      test_saturate();
      test_fast();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
